// File: rtl/channel_allocator.sv
// Per-channel round-robin allocator for BiNoC bidirectional channels; ownership is held until the owner drops its request.
// Optional hold watchdog enabled by defining ALLOC_TIMEOUT_EN (forced release after MAX_HOLD grant cycles).
module channel_allocator #(
    parameter int NUM_PORTS = 10,
    parameter int NUM_CH    = 10,
    parameter int SEL_W     = 4,
    parameter int MAX_HOLD  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*NUM_CH-1:0]   channel_req,
    output logic [NUM_PORTS*NUM_CH-1:0]   channel_gnt,
    output logic [NUM_CH*SEL_W-1:0]       sel,
    output logic [NUM_CH-1:0]             ch_busy,
    output logic [NUM_CH-1:0]             timeout
);

    localparam int                 REQ_EXT_W = 1 << SEL_W;
    localparam int                 SUM_W     = SEL_W + 1;
    localparam logic [SEL_W-1:0]   SEL_IDLE  = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0]   LAST_PORT = SEL_W'(NUM_PORTS - 1);
    localparam logic [SUM_W-1:0]   PORTS_EXT = SUM_W'(NUM_PORTS);
`ifdef ALLOC_TIMEOUT_EN
    localparam int                 CNT_W     = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(MAX_HOLD - 1);
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // The all-ones select code must stay free as the idle marker.
    if (NUM_PORTS > (1 << SEL_W) - 1 || MAX_HOLD < 2) begin : g_param_check
        $error("channel_allocator: unsupported parameter combination");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [REQ_EXT_W-1:0] req_s;
        logic [SEL_W-1:0]     pick_s;
        logic                 pick_valid_s;
        logic                 owner_req_s;
        logic                 release_s;
        logic [SEL_W-1:0]     ptr_next_s;

        state_t               state_r;
        logic [SEL_W-1:0]     owner_r;
        logic [SEL_W-1:0]     ptr_r;
        logic [SEL_W-1:0]     sel_r;
        logic [NUM_PORTS-1:0] gnt_r;
        logic                 busy_r;
`ifdef ALLOC_TIMEOUT_EN
        logic [CNT_W-1:0]     hold_cnt_r;
        logic                 expired_s;
        logic                 timeout_r;
`endif

        // Gather this channel's request column, zero-padded so any select code indexes safely.
        always_comb begin
            req_s = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                req_s[p] = channel_req[p*NUM_CH + c];
            end
        end

        // Round-robin search: first requester at or after ptr_r, wrapping at NUM_PORTS.
        always_comb begin
            logic [SUM_W-1:0] sum_v;
            logic             take_v;
            sum_v        = '0;
            take_v       = 1'b0;
            pick_s       = '0;
            pick_valid_s = 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                sum_v        = {1'b0, ptr_r} + SUM_W'(i);
                sum_v        = (sum_v >= PORTS_EXT) ? (sum_v - PORTS_EXT) : sum_v;
                take_v       = !pick_valid_s && req_s[sum_v[SEL_W-1:0]];
                pick_s       = take_v ? sum_v[SEL_W-1:0] : pick_s;
                pick_valid_s = pick_valid_s | take_v;
            end
        end

        // Release decision and the pointer value that skips past the current owner.
        always_comb begin
            owner_req_s = req_s[owner_r];
            ptr_next_s  = (owner_r == LAST_PORT) ? '0 : (owner_r + SEL_W'(1));
`ifdef ALLOC_TIMEOUT_EN
            expired_s   = owner_req_s && (hold_cnt_r == HOLD_LAST);
            release_s   = !owner_req_s || expired_s;
`else
            release_s   = !owner_req_s;
`endif
        end

        // Channel FSM with registered grant, select, busy and timeout outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r    <= ST_IDLE;
                owner_r    <= '0;
                ptr_r      <= '0;
                sel_r      <= SEL_IDLE;
                gnt_r      <= '0;
                busy_r     <= 1'b0;
`ifdef ALLOC_TIMEOUT_EN
                hold_cnt_r <= '0;
                timeout_r  <= 1'b0;
`endif
            end else begin
                case (state_r)
                    ST_IDLE: begin
`ifdef ALLOC_TIMEOUT_EN
                        timeout_r <= 1'b0;
`endif
                        if (pick_valid_s) begin
                            state_r    <= ST_GRANT;
                            owner_r    <= pick_s;
                            sel_r      <= pick_s;
                            gnt_r      <= NUM_PORTS'(1) << pick_s;
                            busy_r     <= 1'b1;
`ifdef ALLOC_TIMEOUT_EN
                            hold_cnt_r <= '0;
`endif
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_GRANT: begin
                        if (release_s) begin
                            state_r    <= ST_IDLE;
                            sel_r      <= SEL_IDLE;
                            gnt_r      <= '0;
                            busy_r     <= 1'b0;
                            ptr_r      <= ptr_next_s;
`ifdef ALLOC_TIMEOUT_EN
                            hold_cnt_r <= '0;
                            timeout_r  <= expired_s;
`endif
                        end else begin
                            state_r    <= ST_GRANT;
`ifdef ALLOC_TIMEOUT_EN
                            hold_cnt_r <= hold_cnt_r + CNT_W'(1);
                            timeout_r  <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        owner_r    <= '0;
                        sel_r      <= SEL_IDLE;
                        gnt_r      <= '0;
                        busy_r     <= 1'b0;
`ifdef ALLOC_TIMEOUT_EN
                        hold_cnt_r <= '0;
                        timeout_r  <= 1'b0;
`endif
                    end
                endcase
            end
        end

        assign sel[c*SEL_W +: SEL_W] = sel_r;
        assign ch_busy[c]            = busy_r;
`ifdef ALLOC_TIMEOUT_EN
        assign timeout[c]            = timeout_r;
`else
        assign timeout[c]            = 1'b0;
`endif
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_gnt
            assign channel_gnt[p*NUM_CH + c] = gnt_r[p];
        end
    end

endmodule

// Invariant monitor: one owner per channel, grants only follow a request, select/busy consistent.
module channel_allocator_checker #(
    parameter int NUM_PORTS = 10,
    parameter int NUM_CH    = 10,
    parameter int SEL_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*NUM_CH-1:0]   channel_req,
    input  logic [NUM_PORTS*NUM_CH-1:0]   channel_gnt,
    input  logic [NUM_CH*SEL_W-1:0]       sel,
    input  logic [NUM_CH-1:0]             ch_busy
);

    localparam logic [SEL_W-1:0] SEL_IDLE  = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] PORT_LIM  = SEL_W'(NUM_PORTS);

    logic                        armed_r;
    logic [NUM_PORTS*NUM_CH-1:0] req_prev_r;

    // Remember last cycle's requests; checks start one cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_r    <= 1'b0;
            req_prev_r <= '0;
        end else begin
            armed_r    <= 1'b1;
            req_prev_r <= channel_req;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
        logic [NUM_PORTS-1:0] gnt_s;
        logic [NUM_PORTS-1:0] req_prev_s;
        logic [SEL_W-1:0]     sel_s;

        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_col
            assign gnt_s[p]      = channel_gnt[p*NUM_CH + c];
            assign req_prev_s[p] = req_prev_r[p*NUM_CH + c];
        end
        assign sel_s = sel[c*SEL_W +: SEL_W];

        // Sampled values are the outputs of the cycle just ending.
        always @(posedge clk) begin
            if (armed_r && !rst) begin
                a_one_owner: assert ($onehot0(gnt_s));
                a_gnt_req:   assert ((gnt_s & ~req_prev_s) == '0);
                a_busy:      assert (ch_busy[c] == (|gnt_s));
                a_sel_idle:  assert ((sel_s == SEL_IDLE) == !ch_busy[c]);
                a_sel_range: assert ((sel_s == SEL_IDLE) || (sel_s < PORT_LIM));
            end
        end
    end

endmodule
